fb_writer: RTL and testbench

- Framebuffer writer: takes a 32-bit pixel stream and stores it in SDRAM through an Avalon-MM host port using fixed-length write bursts.
- It is the writing end of the framebuffer that the VGA scan-out reads: same linear layout, one 32-bit word per pixel, byte address = 4*(y*HDISP + x).
- Single clock domain (Avalon clock); the pixel source must already be in this domain.

---
 rtl/fb_writer.sv | 181 ++++++++++++++++++
 tb/tb_fb_writer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_writer.sv
// Framebuffer writer: buffers a 32-bit pixel stream in a show-ahead FIFO and
// stores it to SDRAM as fixed-length Avalon-MM write bursts in linear raster order.
module fb_writer #(
    parameter int unsigned HDISP       = 800,
    parameter int unsigned VDISP       = 480,
    parameter int unsigned BURSTSIZE   = 16,
    parameter int unsigned DEPTH_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [31:0]                          pix_data,
    input  logic                                 pix_valid,
    input  logic                                 pix_sof,
    output logic                                 pix_ready,
    output logic [31:0]                          avm_address,
    output logic                                 avm_write,
    output logic [31:0]                          avm_writedata,
    output logic [3:0]                           avm_byteenable,
    output logic [$clog2(BURSTSIZE+1)-1:0]       avm_burstcount,
    output logic                                 avm_read,
    input  logic                                 avm_waitrequest,
    output logic                                 frame_done,
    output logic                                 sof_err
);

    localparam int unsigned DEPTH      = 1 << DEPTH_WIDTH;
    localparam int unsigned CNT_W      = DEPTH_WIDTH + 1;
    localparam int unsigned FRAME      = HDISP * VDISP;
    localparam int unsigned IDX_W      = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int unsigned BC_W       = $clog2(BURSTSIZE + 1);
    localparam logic [31:0] BURST_BYTES = 32'(4 * BURSTSIZE);
    localparam logic [31:0] LAST_ADDR  = BASE_ADDR + 32'(4 * FRAME) - BURST_BYTES;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    // FIFO storage and pointers
    logic [31:0]            mem_q [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    // input side
    logic                   ready_q, ready_d;
    logic                   in_sync_q, in_sync_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   sof_err_q, sof_err_d;
    logic                   accept_c;
    logic                   push_c;

    // burst side
    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic                   write_q, write_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [BC_W-1:0]        beat_q, beat_d;
    logic                   frame_done_q, frame_done_d;
    logic                   pop_c;

    // Input acceptance, frame sync and pixel index tracking
    always_comb begin
        accept_c  = pix_valid && ready_q;
        push_c    = accept_c && (in_sync_q || pix_sof);
        in_sync_d = in_sync_q || push_c;
        idx_d     = idx_q;
        if (push_c) begin
            idx_d = (idx_q == IDX_W'(FRAME - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        sof_err_d = accept_c && pix_sof && in_sync_q && (idx_q != '0);
    end

    // FIFO pointer and occupancy update; ready looks at the next occupancy
    always_comb begin
        wr_ptr_d = push_c ? wr_ptr_q + DEPTH_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + DEPTH_WIDTH'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_d = count_q - CNT_W'(1);
        end
        ready_d = (count_d <= CNT_W'(DEPTH - 2));
    end

    // Burst FSM: next state and registered bus outputs
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        beat_d       = beat_q;
        frame_done_d = 1'b0;
        pop_c        = 1'b0;
        unique case (state_q)
            IDLE: begin
                write_d = 1'b0;
                if (count_q >= CNT_W'(BURSTSIZE)) begin
                    state_d = BURST;
                    write_d = 1'b1;
                    wdata_d = mem_q[rd_ptr_q];
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (write_q && !avm_waitrequest) begin
                    pop_c   = 1'b1;
                    wdata_d = mem_q[rd_ptr_q + DEPTH_WIDTH'(1)];
                    beat_d  = beat_q + BC_W'(1);
                    if (beat_q == BC_W'(BURSTSIZE - 1)) begin
                        state_d = IDLE;
                        write_d = 1'b0;
                        beat_d  = '0;
                        if (addr_q == LAST_ADDR) begin
                            addr_d       = BASE_ADDR;
                            frame_done_d = 1'b1;
                        end else begin
                            addr_d = addr_q + BURST_BYTES;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                write_d = 1'b0;
            end
        endcase
    end

    // FIFO memory is a plain array, no reset needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            in_sync_q    <= 1'b0;
            idx_q        <= '0;
            sof_err_q    <= 1'b0;
            state_q      <= IDLE;
            addr_q       <= BASE_ADDR;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            beat_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            in_sync_q    <= in_sync_d;
            idx_q        <= idx_d;
            sof_err_q    <= sof_err_d;
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            beat_q       <= beat_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_ready      = ready_q;
    assign avm_address    = addr_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;
    assign avm_burstcount = BC_W'(BURSTSIZE);
    assign avm_read       = 1'b0;
    assign frame_done     = frame_done_q;
    assign sof_err        = sof_err_q;

endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer using a reduced 16x4 frame so whole-frame
// wrap behaviour fits in a short run.
module tb_fb_writer;

    localparam int unsigned HD    = 16;
    localparam int unsigned VD    = 4;
    localparam int unsigned BS    = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned FRAME = HD * VD;
    localparam int unsigned BC_W  = $clog2(BS + 1);
    localparam int unsigned NVEC  = 34;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     pix_data = '0;
    logic            pix_valid = 1'b0;
    logic            pix_sof = 1'b0;
    logic            pix_ready;
    logic [31:0]     avm_address;
    logic            avm_write;
    logic [31:0]     avm_writedata;
    logic [3:0]      avm_byteenable;
    logic [BC_W-1:0] avm_burstcount;
    logic            avm_read;
    logic            avm_waitrequest = 1'b0;
    logic            frame_done;
    logic            sof_err;

    fb_writer #(
        .HDISP(HD), .VDISP(VD), .BURSTSIZE(BS), .DEPTH_WIDTH(DW), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_ready(pix_ready),
        .avm_address(avm_address), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_burstcount(avm_burstcount), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .frame_done(frame_done), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor: records accepted beats and pulse counts, checks hold-under-stall
    logic [63:0] beats[$];
    int          fd_cnt, fd_beat, se_cnt, stall_cnt;
    logic        prev_stall;
    logic [31:0] prev_addr, prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_write", 32'(avm_write), 32'd1);
                chk("hold_addr", avm_address, prev_addr);
                chk("hold_data", avm_writedata, prev_data);
            end
            if (avm_write && !avm_waitrequest) beats.push_back({avm_address, avm_writedata});
            if (avm_write && avm_waitrequest) stall_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_beat = beats.size();
            end
            if (sof_err) se_cnt++;
            prev_stall = avm_write && avm_waitrequest;
            prev_addr  = avm_address;
            prev_data  = avm_writedata;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        avm_waitrequest = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(pix_ready), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_addr", avm_address, 32'h0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_soferr", 32'(sof_err), 32'd0);
        @(posedge clk); #1;
        beats.delete();
        fd_cnt = 0; fd_beat = -1; se_cnt = 0; stall_cnt = 0;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [31:0] d, input logic s);
        int t;
        t = 0;
        pix_data = d; pix_sof = s; pix_valid = 1'b1;
        while (!pix_ready && t < 2000) begin @(posedge clk); #1; t++; end
        chk("send_timeout", 32'(t >= 2000), 32'd0);
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0;
    endtask

    task automatic wait_beats(input int n);
        int t;
        t = 0;
        while (beats.size() < n && t < 5000) begin @(posedge clk); #1; t++; end
        chk("drain_timeout", 32'(t >= 5000), 32'd0);
        repeat (20) begin @(posedge clk); #1; end
    endtask

    task automatic cmp_beats(input string name, input logic [63:0] exp[$]);
        chk({name, "_nbeats"}, 32'(beats.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < beats.size(); i++) begin
            chk({name, "_addr"}, beats[i][63:32], exp[i][63:32]);
            chk({name, "_data"}, beats[i][31:0], exp[i][31:0]);
        end
    endtask

    typedef struct {
        logic        valid;
        logic        sof;
        logic [31:0] data;
        logic        exp_write;
        logic [31:0] exp_wdata;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t        tbl [NVEC];
    logic [63:0] exp_q[$];

    initial begin
        // Cycle table: 16 pixels pushed in rows 0..15, FIFO reaches 16 after
        // row 15's edge, write appears in row 17 and stays for 16 beats.
        for (int k = 0; k < NVEC; k++) begin
            tbl[k].valid     = (k < 16);
            tbl[k].sof       = (k == 0);
            tbl[k].data      = (k < 16) ? 32'(k + 1) : 32'h0;
            tbl[k].exp_write = (k >= 17 && k <= 32);
            tbl[k].exp_wdata = 32'(k - 16);
            tbl[k].exp_addr  = (k <= 32) ? 32'h0 : 32'h40;
        end

        // reset state and constant outputs
        do_reset();
        chk("byteenable", 32'(avm_byteenable), 32'hF);
        chk("burstcount", 32'(avm_burstcount), 32'd16);
        chk("read", 32'(avm_read), 32'd0);

        // single burst, cycle-exact
        for (int k = 0; k < NVEC; k++) begin
            pix_valid = tbl[k].valid;
            pix_sof   = tbl[k].sof;
            pix_data  = tbl[k].data;
            @(negedge clk);
            chk("t1_ready", 32'(pix_ready), 32'd1);
            chk("t1_write", 32'(avm_write), 32'(tbl[k].exp_write));
            if (tbl[k].exp_write) begin
                chk("t1_wdata", avm_writedata, tbl[k].exp_wdata);
                chk("t1_addr", avm_address, tbl[k].exp_addr);
            end
            if (k == NVEC - 1) chk("t1_next_addr", avm_address, tbl[k].exp_addr);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0; pix_sof = 1'b0;
        chk("t1_fdone", 32'(fd_cnt), 32'd0);

        // pixels before sof are discarded
        do_reset();
        for (int i = 0; i < 32; i++) send(32'hA00 + 32'(i), 1'b0);
        for (int i = 0; i < 16; i++) send(32'h100 + 32'(i), i == 0);
        wait_beats(16);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back({32'h0, 32'h100 + 32'(i)});
        cmp_beats("t2", exp_q);
        chk("t2_soferr", 32'(se_cnt), 32'd0);

        // waitrequest stalls on beat 1 and beat 9
        do_reset();
        fork
            begin
                for (int i = 0; i < 16; i++) send(32'h300 + 32'(i), i == 0);
            end
            begin
                int t;
                t = 0;
                while (!avm_write && t < 500) begin @(posedge clk); #1; t++; end
                avm_waitrequest = 1'b1;
                repeat (5) begin @(posedge clk); #1; end
                avm_waitrequest = 1'b0;
                while (beats.size() < 8 && t < 1000) begin @(posedge clk); #1; t++; end
                avm_waitrequest = 1'b1;
                repeat (5) begin @(posedge clk); #1; end
                avm_waitrequest = 1'b0;
                chk("t3_stall_timeout", 32'(t >= 500), 32'd0);
            end
        join
        wait_beats(16);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back({32'h0, 32'h300 + 32'(i)});
        cmp_beats("t3", exp_q);
        chk("t3_stall_cycles", 32'(stall_cnt), 32'd10);

        // full frame, then start of second frame wraps to base
        do_reset();
        for (int i = 0; i < FRAME; i++) send(32'h4000 + 32'(i), i == 0);
        for (int i = 0; i < 16; i++) send(32'h5000 + 32'(i), i == 0);
        wait_beats(FRAME + 16);
        exp_q.delete();
        for (int i = 0; i < FRAME; i++) exp_q.push_back({32'((i / 16) * 64), 32'h4000 + 32'(i)});
        for (int i = 0; i < 16; i++) exp_q.push_back({32'h0, 32'h5000 + 32'(i)});
        cmp_beats("t4", exp_q);
        chk("t4_fdone_cnt", 32'(fd_cnt), 32'd1);
        chk("t4_fdone_at", 32'(fd_beat), 32'(FRAME));
        chk("t4_soferr", 32'(se_cnt), 32'd0);

        // permanent stall: ready drops at 255 stored words, then drains in order
        do_reset();
        avm_waitrequest = 1'b1;
        begin
            int n;
            n = 0;
            for (int c = 0; c < 320; c++) begin
                pix_data = 32'h600 + 32'(n);
                pix_sof = (n == 0);
                pix_valid = 1'b1;
                @(negedge clk);
                if (pix_ready) n++;
                @(posedge clk); #1;
            end
            pix_valid = 1'b0; pix_sof = 1'b0;
            @(negedge clk);
            chk("t5_accepted", 32'(n), 32'd255);
            chk("t5_ready_low", 32'(pix_ready), 32'd0);
            chk("t5_no_xfer", 32'(beats.size()), 32'd0);
            @(posedge clk); #1;
            avm_waitrequest = 1'b0;
            send(32'h600 + 32'd255, 1'b0);
        end
        wait_beats(256);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back({32'(((i / 16) % 4) * 64), 32'h600 + 32'(i)});
        cmp_beats("t5", exp_q);
        chk("t5_fdone_cnt", 32'(fd_cnt), 32'd4);

        // misaligned sof mid-frame
        do_reset();
        for (int i = 0; i < FRAME; i++) send(32'h7000 + 32'(i), (i == 0) || (i == 40));
        wait_beats(FRAME);
        exp_q.delete();
        for (int i = 0; i < FRAME; i++) exp_q.push_back({32'((i / 16) * 64), 32'h7000 + 32'(i)});
        cmp_beats("t6", exp_q);
        chk("t6_soferr_cnt", 32'(se_cnt), 32'd1);
        chk("t6_fdone_cnt", 32'(fd_cnt), 32'd1);
        chk("t6_fdone_at", 32'(fd_beat), 32'(FRAME));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
